alu_issue_sched: RTL
====================

Name: alu_issue_sched

Overview:
- Shares one ALU execution slot between NREQ micro-op requesters, for example decode slots or a replay path.
- Each accepted micro_op_t is evaluated through the ALU package function alu().
- m_imul_l and m_imul_h are modelled as occupying the slot for MUL_LAT cycles. All other opcodes occupy it for 1 cycle.
- The result goes to a 1-entry output register with valid/ready backpressure. Illegal opcodes are reported on an error port instead of ending simulation.

Parameters:
- NREQ, 2, number of requesters (legal 1..8).
- MUL_LAT, 3, cycles from accept to res_valid for m_imul_l/m_imul_h (legal 2..15).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- req_valid  input  NREQ  per-requester micro-op valid.
- req_mop  input  NREQ x micro_op_t  per-requester micro-op.
- req_ready  output  NREQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- flush  input  1  discard in-flight op and output register.
- res_valid  output  1  result valid.
- res_mop  output  micro_op_t  alu() result (dst_val filled).
- res_src  output  $clog2(NREQ) (min 1)  requester index of res_mop.
- res_ready  input  1  consumer accepts result.
- err_valid  output  1  one-cycle pulse: unsupported opcode accepted.
- err_opcode  output  opcode width  offending opcode.
- stat_issued  output  32  count of accepted ops, wraps at 2^32.

Behaviour:
- Reset (reset_n low at edge):
  - State goes to IDLE.
  - res_valid=0, err_valid=0, req_ready=0, rr_ptr=0, mul_cnt=0, stat_issued=0.
  - res_mop, res_src and err_opcode are don't-care.
  - Reset mid-multiply drops the op; no result or error is ever produced for it.
- States:
  - IDLE: slot free.
  - MUL: mul_cnt counting down.
  - An output-register-full condition is tracked by res_valid, not by a separate state.
- can_issue = (state==IDLE) & (!res_valid | res_ready) & !flush.
- Arbitration:
  - When can_issue, req_ready is one-hot on the first i with req_valid[i], searching from rr_ptr upward and wrapping mod NREQ.
  - When no request is valid, req_ready=0.
  - req_ready is combinational from req_valid; req_valid must not depend on req_ready.
  - After a grant to index g, rr_ptr = (g+1) mod NREQ.
  - rr_ptr is unchanged when nothing is granted.
- Single-cycle ops (m_lea, m_cpy, m_cpy_f, m_add, m_sub, m_and, m_or, m_xor, m_shl, m_shr):
  - Accepted in cycle T; res_valid=1 in T+1 with res_mop=alu(mop) and res_src=g.
  - Back-to-back issue each cycle is allowed while the consumer keeps res_ready=1 (throughput 1/cycle).
- m_imul_l / m_imul_h:
  - On accept, the op is latched, state goes to MUL and mul_cnt = MUL_LAT-1.
  - mul_cnt decrements each cycle.
  - When mul_cnt==1 and the output register is free or draining, res_valid=1 in the next cycle (T+MUL_LAT) and state goes to IDLE.
  - If the output register is held, the scheduler stays in MUL with mul_cnt=1 until it is free.
  - req_ready=0 for the whole time in MUL.
- Unsupported opcode:
  - Accepted normally and counted in stat_issued.
  - err_valid=1 and err_opcode=opcode in T+1; no res_valid.
  - The slot is free again in T+1.
- Output register:
  - While res_valid & !res_ready, res_mop and res_src are held stable.
  - res_valid drops in the cycle after the handshake unless a new result loads.
  - Simultaneous drain and load in one cycle is required (no bubble).
- flush:
  - Next cycle: res_valid=0, state=IDLE, mul_cnt=0, err_valid=0.
  - req_ready=0 during the flush cycle.
  - rr_ptr and stat_issued are kept.
  - flush wins over every other event in the same cycle.
- stat_issued increments by 1 on each accepted transfer, including illegal opcodes.

Test Plan:
1. After reset, req_valid=2'b11 with req0 m_add src0=5 src1=7 and req1 m_sub src0=3 src1=3 → grant req0 first: res val=12, cf=0, zf=0, res_src=0 at T+1. Then req1: val=0, zf=1, pf=1, res_src=1 at T+2. stat_issued=2.
2. Continuous req_valid on both requesters, res_ready=1, 6 cycles → grants alternate 0,1,0,1,0,1; one result per cycle.
3. m_imul_l src0=-2 src1=3 with MUL_LAT=3 → req_ready=0 for 2 cycles, res val=0xFFFF_FFFF_FFFF_FFFA, cf=of=0 at T+3. Then m_imul_h src0=2^62 src1=4 → val=1, cf=of=1.
4. res_ready=0 for 4 cycles after an m_or result → res_mop stable, req_ready=0. res_ready=1 → drain and next op load in the same cycle with no bubble.
5. Opcode outside the supported set → err_valid pulse of exactly 1 cycle with err_opcode correct, no res_valid, stat_issued incremented.
6. flush during MUL (mul_cnt=1) and reset_n=0 during MUL → no result emitted; state IDLE; req_ready reasserts the cycle after flush/reset ends.

Source files
------------

// File: rtl/alu_issue_sched_if.sv
// alu_pkg: micro-op type, opcodes and the reference ALU function shared by the
//   scheduler and anything that produces or consumes micro-ops.
// alu_issue_sched_if: requester/result/error/statistics bundle of the ALU issue scheduler.
//   req_valid/req_mop/req_ready : per-requester micro-op handshake (one-hot ready)
//   flush                       : discard in-flight op and output register
//   res_valid/res_mop/res_src   : result register, backpressured by res_ready
//   err_valid/err_opcode        : one-cycle pulse for an accepted unsupported opcode
//   stat_issued                 : count of accepted ops
//   Modports: master = requester/consumer side, slave = scheduler side.
package alu_pkg;

  typedef enum logic [4:0] {
    m_lea    = 5'd0,
    m_cpy    = 5'd1,
    m_cpy_f  = 5'd2,
    m_add    = 5'd3,
    m_sub    = 5'd4,
    m_and    = 5'd5,
    m_or     = 5'd6,
    m_xor    = 5'd7,
    m_shl    = 5'd8,
    m_shr    = 5'd9,
    m_imul_l = 5'd10,
    m_imul_h = 5'd11
  } opcode_e;

  typedef struct packed {
    opcode_e     opcode;
    logic [63:0] src0;
    logic [63:0] src1;
    logic [63:0] dst_val;
    logic        cf;
    logic        zf;
    logic        sf;
    logic        of;
    logic        pf;
  } micro_op_t;

  function automatic logic is_legal(input opcode_e op);
    return (op <= m_imul_h);
  endfunction

  function automatic logic is_mul(input opcode_e op);
    return (op == m_imul_l) || (op == m_imul_h);
  endfunction

  // lea/cpy leave flags untouched; every other op rewrites them.
  // pf follows x86: set when the low result byte has even parity.
  function automatic micro_op_t alu(input micro_op_t m);
    micro_op_t          r;
    logic [64:0]        s;
    logic signed [127:0] a;
    logic signed [127:0] b;
    logic signed [127:0] p;
    logic [63:0]        v;
    logic               wr;
    logic               cf;
    logic               of;
    r  = m;
    v  = m.dst_val;
    wr = 1'b1;
    cf = 1'b0;
    of = 1'b0;
    a  = {{64{m.src0[63]}}, m.src0};
    b  = {{64{m.src1[63]}}, m.src1};
    p  = a * b;
    s  = '0;
    unique case (m.opcode)
      m_lea:   begin v = m.src0 + m.src1; wr = 1'b0; end
      m_cpy:   begin v = m.src0;          wr = 1'b0; end
      m_cpy_f: v = m.src0;
      m_add: begin
        s  = {1'b0, m.src0} + {1'b0, m.src1};
        v  = s[63:0];
        cf = s[64];
        of = (m.src0[63] == m.src1[63]) && (v[63] != m.src0[63]);
      end
      m_sub: begin
        s  = {1'b0, m.src0} - {1'b0, m.src1};
        v  = s[63:0];
        cf = s[64];
        of = (m.src0[63] != m.src1[63]) && (v[63] != m.src0[63]);
      end
      m_and:   v = m.src0 & m.src1;
      m_or:    v = m.src0 | m.src1;
      m_xor:   v = m.src0 ^ m.src1;
      m_shl:   v = m.src0 << m.src1[5:0];
      m_shr:   v = m.src0 >> m.src1[5:0];
      m_imul_l, m_imul_h: begin
        v  = (m.opcode == m_imul_l) ? p[63:0] : p[127:64];
        // Overflow when the full product does not fit a signed 64-bit value.
        cf = (p != {{64{p[63]}}, p[63:0]});
        of = cf;
      end
      default: wr = 1'b0;
    endcase
    r.dst_val = v;
    if (wr) begin
      r.cf = cf;
      r.of = of;
      r.zf = (v == 64'd0);
      r.sf = v[63];
      r.pf = ~^v[7:0];
    end
    return r;
  endfunction

endpackage

interface alu_issue_sched_if #(
  parameter int unsigned NREQ = 2
);
  import alu_pkg::*;
  localparam int unsigned SrcW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]            req_valid;
  micro_op_t [NREQ-1:0]       req_mop;
  logic [NREQ-1:0]            req_ready;
  logic                       flush;
  logic                       res_valid;
  micro_op_t                  res_mop;
  logic [SrcW-1:0]            res_src;
  logic                       res_ready;
  logic                       err_valid;
  logic [4:0]                 err_opcode;
  logic [31:0]                stat_issued;

  modport master (
    output req_valid, req_mop, flush, res_ready,
    input  req_ready, res_valid, res_mop, res_src, err_valid, err_opcode, stat_issued
  );

  modport slave (
    input  req_valid, req_mop, flush, res_ready,
    output req_ready, res_valid, res_mop, res_src, err_valid, err_opcode, stat_issued
  );
endinterface

// File: rtl/alu_issue_sched.sv
// alu_issue_sched: round-robin sharing of one ALU slot between NREQ requesters.
//   clk_i    : clock, rising edge
//   reset_ni : synchronous active-low reset
//   bus      : alu_issue_sched_if.slave (requests, result register, error pulse, stats)
// Single-cycle ops produce a result one cycle after accept; imul_l/imul_h hold the
// slot for MUL_LAT cycles. Unsupported opcodes pulse err_valid instead of a result.
module alu_issue_sched #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  alu_issue_sched_if.slave   bus
);
  import alu_pkg::*;

  localparam int unsigned SrcW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e          state_q, state_d;
  logic [3:0]      mul_cnt_q, mul_cnt_d;
  logic [SrcW-1:0] rr_ptr_q, rr_ptr_d;
  logic            res_valid_q, res_valid_d;
  micro_op_t       res_mop_q, res_mop_d;
  logic [SrcW-1:0] res_src_q, res_src_d;
  micro_op_t       mul_mop_q, mul_mop_d;
  logic [SrcW-1:0] mul_src_q, mul_src_d;
  logic            err_valid_q, err_valid_d;
  logic [4:0]      err_opcode_q, err_opcode_d;
  logic [31:0]     stat_q, stat_d;

  logic            out_free;
  logic            can_issue;
  logic            gnt_found;
  logic [SrcW-1:0] gnt_idx;
  int unsigned     idx;
  micro_op_t       gnt_mop;

  // Output register can take a new value when empty or draining this cycle.
  assign out_free  = !res_valid_q || bus.res_ready;
  // Gated by reset so nothing transfers (or is counted) while reset is held.
  assign can_issue = reset_ni && (state_q == StIdle) && out_free && !bus.flush;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NREQ;
      if (!gnt_found && bus.req_valid[SrcW'(idx)]) begin
        gnt_found = 1'b1;
        gnt_idx   = SrcW'(idx);
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (can_issue && gnt_found) bus.req_ready[gnt_idx] = 1'b1;
  end

  assign gnt_mop = bus.req_mop[gnt_idx];

  always_comb begin
    state_d      = state_q;
    mul_cnt_d    = mul_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    res_valid_d  = res_valid_q && !bus.res_ready;
    res_mop_d    = res_mop_q;
    res_src_d    = res_src_q;
    mul_mop_d    = mul_mop_q;
    mul_src_d    = mul_src_q;
    err_valid_d  = 1'b0;
    err_opcode_d = err_opcode_q;
    stat_d       = stat_q;

    if (state_q == StMul) begin
      if (mul_cnt_q > 4'd1) begin
        mul_cnt_d = mul_cnt_q - 4'd1;
      end else if (out_free) begin
        res_valid_d = 1'b1;
        res_mop_d   = alu(mul_mop_q);
        res_src_d   = mul_src_q;
        mul_cnt_d   = 4'd0;
        state_d     = StIdle;
      end
    end

    if (can_issue && gnt_found) begin
      stat_d   = stat_q + 32'd1;
      rr_ptr_d = SrcW'((32'(gnt_idx) + 32'd1) % NREQ);
      if (!is_legal(gnt_mop.opcode)) begin
        err_valid_d  = 1'b1;
        err_opcode_d = gnt_mop.opcode;
      end else if (is_mul(gnt_mop.opcode)) begin
        mul_mop_d = gnt_mop;
        mul_src_d = gnt_idx;
        mul_cnt_d = 4'(MUL_LAT - 1);
        state_d   = StMul;
      end else begin
        res_valid_d = 1'b1;
        res_mop_d   = alu(gnt_mop);
        res_src_d   = gnt_idx;
      end
    end

    // Flush overrides everything except the arbitration pointer and statistics.
    if (bus.flush) begin
      res_valid_d = 1'b0;
      err_valid_d = 1'b0;
      state_d     = StIdle;
      mul_cnt_d   = 4'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q      <= StIdle;
      mul_cnt_q    <= 4'd0;
      rr_ptr_q     <= '0;
      res_valid_q  <= 1'b0;
      res_mop_q    <= '0;
      res_src_q    <= '0;
      mul_mop_q    <= '0;
      mul_src_q    <= '0;
      err_valid_q  <= 1'b0;
      err_opcode_q <= '0;
      stat_q       <= 32'd0;
    end else begin
      state_q      <= state_d;
      mul_cnt_q    <= mul_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      res_valid_q  <= res_valid_d;
      res_mop_q    <= res_mop_d;
      res_src_q    <= res_src_d;
      mul_mop_q    <= mul_mop_d;
      mul_src_q    <= mul_src_d;
      err_valid_q  <= err_valid_d;
      err_opcode_q <= err_opcode_d;
      stat_q       <= stat_d;
    end
  end

  assign bus.res_valid   = res_valid_q;
  assign bus.res_mop     = res_mop_q;
  assign bus.res_src     = res_src_q;
  assign bus.err_valid   = err_valid_q;
  assign bus.err_opcode  = err_opcode_q;
  assign bus.stat_issued = stat_q;

endmodule
